// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle for the multicycle MIPS main controller.
// Optional MC_RETIRE_CNT_EN adds the 32-bit retired-instruction count.
interface mc_ctrl_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        eq;
  logic        mem_ready;
  logic        pc_en;
  logic [1:0]  pcsrc;
  logic        iord;
  logic        memwrite;
  logic        irwrite;
  logic        regdst;
  logic        memtoreg;
  logic        regwrite;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic        ext_zero;
  logic [2:0]  aluop;
  logic        illegal;
`ifdef MC_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  // Controller side: consumes IR fields and datapath status, drives controls.
  modport master (
    input  op, funct, eq, mem_ready,
`ifdef MC_RETIRE_CNT_EN
    output retired,
`endif
    output pc_en, pcsrc, iord, memwrite, irwrite, regdst, memtoreg,
    output regwrite, alusrca, alusrcb, ext_zero, aluop, illegal
  );

  // Datapath side.
  modport slave (
    output op, funct, eq, mem_ready,
`ifdef MC_RETIRE_CNT_EN
    input  retired,
`endif
    input  pc_en, pcsrc, iord, memwrite, irwrite, regdst, memtoreg,
    input  regwrite, alusrca, alusrcb, ext_zero, aluop, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS main controller: fetch/decode/execute/memory/writeback
// sequencing with combinational control outputs from the current state.
// Optional feature macro: MC_RETIRE_CNT_EN (retired-instruction counter).
module mc_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input logic       clk,
  input logic       reset,
  mc_ctrl_if.master ctrl
);

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_RTEX   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BEQ    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_IMMEX  = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_IMMWB  = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(11);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_OR   = 6'b100101;

  localparam logic [2:0] ALU_LUI = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next;
  logic               rt_ok;
  logic               legal;

  // Supported R-type functions and overall opcode legality for DECODE.
  assign rt_ok = (ctrl.funct == FN_ADD) || (ctrl.funct == FN_ADDU) || (ctrl.funct == FN_OR);
  assign legal = (ctrl.op == OP_LW) || (ctrl.op == OP_SW) || (ctrl.op == OP_BEQ) ||
                 (ctrl.op == OP_ADDIU) || (ctrl.op == OP_ORI) || (ctrl.op == OP_LUI) ||
                 (ctrl.op == OP_J) || ((ctrl.op == OP_RTYPE) && rt_ok);

  // State register; reset restarts at FETCH even mid-instruction.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  // Next-state selection.
  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:  next = ctrl.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW:              next = S_MEMADR;
          OP_RTYPE:                  next = rt_ok ? S_RTEX : S_FETCH;
          OP_BEQ:                    next = S_BEQ;
          OP_ADDIU, OP_ORI, OP_LUI:  next = S_IMMEX;
          OP_J:                      next = S_JUMP;
          default:                   next = S_FETCH;
        endcase
      end
      S_MEMADR: next = (ctrl.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next = ctrl.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next = ctrl.mem_ready ? S_FETCH : S_MEMWR;
      S_RTEX:   next = S_ALUWB;
      S_IMMEX:  next = S_IMMWB;
      default:  next = S_FETCH;
    endcase
  end

  // Control outputs; reset masks every write strobe so no edge under reset writes.
  always_comb begin
    ctrl.pc_en    = 1'b0;
    ctrl.pcsrc    = 2'b00;
    ctrl.iord     = 1'b0;
    ctrl.memwrite = 1'b0;
    ctrl.irwrite  = 1'b0;
    ctrl.regdst   = 1'b0;
    ctrl.memtoreg = 1'b0;
    ctrl.regwrite = 1'b0;
    ctrl.alusrca  = 1'b0;
    ctrl.alusrcb  = 2'b00;
    ctrl.ext_zero = 1'b0;
    ctrl.aluop    = ALU_LUI;
    ctrl.illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = ALU_ADD;
        ctrl.irwrite = ctrl.mem_ready;
        ctrl.pc_en   = ctrl.mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb = 2'b11;
        ctrl.aluop   = ALU_ADD;
        ctrl.illegal = !legal;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = (ctrl.funct == FN_OR) ? ALU_OR : ALU_ADD;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQ: begin
        ctrl.alusrca = 1'b1;
        ctrl.pcsrc   = 2'b01;
        ctrl.pc_en   = ctrl.eq;
      end
      S_IMMEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.alusrcb  = 2'b10;
        ctrl.ext_zero = (ctrl.op == OP_ORI) || (ctrl.op == OP_LUI);
        if (ctrl.op == OP_ORI)      ctrl.aluop = ALU_OR;
        else if (ctrl.op == OP_LUI) ctrl.aluop = ALU_LUI;
        else                        ctrl.aluop = ALU_ADD;
      end
      S_IMMWB: ctrl.regwrite = 1'b1;
      S_JUMP: begin
        ctrl.pcsrc = 2'b10;
        ctrl.pc_en = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ctrl.pc_en    = 1'b0;
      ctrl.irwrite  = 1'b0;
      ctrl.regwrite = 1'b0;
      ctrl.memwrite = 1'b0;
      ctrl.illegal  = 1'b0;
    end
  end

`ifdef MC_RETIRE_CNT_EN
  logic retire_c;

  // Completing states that hand back to FETCH; illegal decodes are not counted.
  assign retire_c = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                    (state == S_IMMWB) || (state == S_JUMP) ||
                    ((state == S_MEMWR) && ctrl.mem_ready);

  // Retired-instruction counter, wrapping at 32 bits.
  always_ff @(posedge clk) begin
    if (reset)         ctrl.retired <= 32'd0;
    else if (retire_c) ctrl.retired <= ctrl.retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control vectors are built
// from the instruction class and queued; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic reset;

  mc_ctrl_if bus ();

  mc_ctrl #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] A_LUI = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_ADD = 3'b010;

  localparam int K_LW = 0, K_SW = 1, K_RT = 2, K_BEQ = 3, K_IMM = 4, K_J = 5, K_BAD = 6;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       ext_zero;
    logic [2:0] aluop;
    logic       illegal;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic        strobes_only;
    logic [31:0] retired;
  } exp_t;

  typedef struct {
    logic       mr;
    logic [5:0] op;
    logic [5:0] funct;
    logic       eq;
    vec_t       v;
    logic       retire;
  } cyc_t;

  exp_t        exp_q[$];
  cyc_t        plan[$];
  logic [31:0] retired_m;
  int          total = 0;
  int          bad = 0;
  int          cyc_n = 0;

  // Instruction class from the opcode/function table.
  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return (f == 6'b100000 || f == 6'b100001 || f == 6'b100101) ? K_RT : K_BAD;
      6'b000100: return K_BEQ;
      6'b001001, 6'b001101, 6'b001111: return K_IMM;
      6'b000010: return K_J;
      default:   return K_BAD;
    endcase
  endfunction

  function automatic logic pick_eq(input int eqm);
    if (eqm == 2) return 1'($urandom);
    return (eqm == 1);
  endfunction

  task automatic add(input logic mr, input logic [5:0] o, input logic [5:0] f,
                     input logic e, input vec_t v, input logic ret);
    cyc_t c;
    c.mr = mr; c.op = o; c.funct = f; c.eq = e; c.v = v; c.retire = ret;
    plan.push_back(c);
  endtask

  task automatic step(input logic rst, input cyc_t c, input exp_t e);
    reset         = rst;
    bus.mem_ready = c.mr;
    bus.op        = c.op;
    bus.funct     = c.funct;
    bus.eq        = c.eq;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Build the cycle-by-cycle plan for one instruction, then play it.
  // rst_at >= 0 asserts reset on that cycle and abandons the instruction.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int eqm,
                           input int fwait, input int mwait, input int rst_at);
    vec_t v;
    int   k;
    logic e;
    plan.delete();
    k = classify(o, f);
    for (int i = 0; i < fwait; i++) begin
      v = '0; v.alusrcb = 2'b01; v.aluop = A_ADD;
      add(1'b0, 6'($urandom), 6'($urandom), pick_eq(eqm), v, 1'b0);
    end
    v = '0; v.alusrcb = 2'b01; v.aluop = A_ADD; v.pc_en = 1'b1; v.irwrite = 1'b1;
    add(1'b1, 6'($urandom), 6'($urandom), pick_eq(eqm), v, 1'b0);
    v = '0; v.alusrcb = 2'b11; v.aluop = A_ADD; v.illegal = (k == K_BAD);
    add(1'($urandom), o, f, pick_eq(eqm), v, 1'b0);
    if (k == K_LW || k == K_SW) begin
      v = '0; v.alusrca = 1'b1; v.alusrcb = 2'b10; v.aluop = A_ADD;
      add(1'($urandom), o, f, pick_eq(eqm), v, 1'b0);
      for (int i = 0; i <= mwait; i++) begin
        v = '0; v.iord = 1'b1; v.memwrite = (k == K_SW);
        add(i == mwait, o, f, pick_eq(eqm), v, (k == K_SW) && (i == mwait));
      end
      if (k == K_LW) begin
        v = '0; v.memtoreg = 1'b1; v.regwrite = 1'b1;
        add(1'($urandom), o, f, pick_eq(eqm), v, 1'b1);
      end
    end else if (k == K_RT) begin
      v = '0; v.alusrca = 1'b1; v.aluop = (f == 6'b100101) ? A_OR : A_ADD;
      add(1'($urandom), o, f, pick_eq(eqm), v, 1'b0);
      v = '0; v.regdst = 1'b1; v.regwrite = 1'b1;
      add(1'($urandom), o, f, pick_eq(eqm), v, 1'b1);
    end else if (k == K_BEQ) begin
      e = pick_eq(eqm);
      v = '0; v.alusrca = 1'b1; v.pcsrc = 2'b01; v.pc_en = e;
      add(1'($urandom), o, f, e, v, 1'b1);
    end else if (k == K_IMM) begin
      v = '0; v.alusrca = 1'b1; v.alusrcb = 2'b10;
      v.aluop    = (o == 6'b001101) ? A_OR : ((o == 6'b001111) ? A_LUI : A_ADD);
      v.ext_zero = (o == 6'b001101) || (o == 6'b001111);
      add(1'($urandom), o, f, pick_eq(eqm), v, 1'b0);
      v = '0; v.regwrite = 1'b1;
      add(1'($urandom), o, f, pick_eq(eqm), v, 1'b1);
    end else if (k == K_J) begin
      v = '0; v.pcsrc = 2'b10; v.pc_en = 1'b1;
      add(1'($urandom), o, f, pick_eq(eqm), v, 1'b1);
    end
    for (int i = 0; i < plan.size(); i++) begin
      exp_t x;
      if (i == rst_at) begin
        x.v = '0; x.strobes_only = 1'b1; x.retired = 32'd0;
        step(1'b1, plan[i], x);
        retired_m = 32'd0;
        return;
      end
      x.v = plan[i].v; x.strobes_only = 1'b0; x.retired = retired_m;
      step(1'b0, plan[i], x);
      if (plan[i].retire) retired_m = retired_m + 32'd1;
    end
  endtask

  // Monitor: the DUT presents a full control vector every cycle.
  always @(negedge clk) begin
    exp_t e;
    vec_t a;
    logic ok;
    cyc_n++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{bus.pc_en, bus.pcsrc, bus.iord, bus.memwrite, bus.irwrite, bus.regdst,
            bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb, bus.ext_zero,
            bus.aluop, bus.illegal};
      total++;
      if (e.strobes_only)
        ok = ({a.pc_en, a.memwrite, a.irwrite, a.regwrite, a.illegal} == 5'b0);
      else
        ok = (a == e.v);
`ifdef MC_RETIRE_CNT_EN
      if (!e.strobes_only && bus.retired != e.retired) ok = 1'b0;
      if (!ok) $display("FAIL ctrl_vec cyc=%0d got=%05h want=%05h strobes_only=%0d retired got=%0d want=%0d",
                        cyc_n, a, e.v, e.strobes_only, bus.retired, e.retired);
`else
      if (!ok) $display("FAIL ctrl_vec cyc=%0d got=%05h want=%05h strobes_only=%0d",
                        cyc_n, a, e.v, e.strobes_only);
`endif
      if (!ok) bad++;
    end
  end

  initial begin
    cyc_t rc;
    exp_t rx;
    reset = 1'b1;
    bus.mem_ready = 1'b1; bus.op = 6'd0; bus.funct = 6'd0; bus.eq = 1'b0;
    @(posedge clk);
    #1;
    rc.mr = 1'b1; rc.op = 6'd0; rc.funct = 6'd0; rc.eq = 1'b0; rc.v = '0; rc.retire = 1'b0;
    rx.v = '0; rx.strobes_only = 1'b1; rx.retired = 32'd0;
    step(1'b1, rc, rx);
    step(1'b1, rc, rx);
    retired_m = 32'd0;

    run_instr(6'b100011, 6'd0, 2, 0, 0, -1);        // lw, no waits
    run_instr(6'b101011, 6'd0, 2, 0, 3, -1);        // sw, 3 wait cycles
    run_instr(6'b001101, 6'd7, 2, 0, 0, -1);        // ori
    run_instr(6'b001111, 6'd9, 2, 1, 0, -1);        // lui
    run_instr(6'b001001, 6'd3, 2, 0, 0, -1);        // addiu
    run_instr(6'b000000, 6'b100000, 2, 0, 0, -1);   // add
    run_instr(6'b000000, 6'b100001, 2, 0, 0, -1);   // addu
    run_instr(6'b000000, 6'b100101, 2, 0, 0, -1);   // or
    run_instr(6'b000100, 6'd0, 1, 0, 0, -1);        // beq taken
    run_instr(6'b000100, 6'd0, 0, 0, 0, -1);        // beq not taken
    run_instr(6'b000010, 6'd0, 2, 0, 0, -1);        // j
    run_instr(6'b111111, 6'd0, 2, 0, 0, -1);        // illegal op
    run_instr(6'b000000, 6'b100010, 2, 0, 0, -1);   // illegal funct
    run_instr(6'b100011, 6'd0, 2, 0, 2, 3);         // reset in MEMRD
    run_instr(6'b001001, 6'd0, 2, 0, 0, -1);        // 3 retire + 1 illegal after reset
    run_instr(6'b000010, 6'd0, 2, 0, 0, -1);
    run_instr(6'b111111, 6'd0, 2, 0, 0, -1);
    run_instr(6'b101011, 6'd0, 2, 0, 1, -1);
    run_instr(6'b101011, 6'd0, 2, 0, 2, 3);         // reset in MEMWR
    run_instr(6'b100011, 6'd0, 2, 0, 0, 4);         // reset in MEMWB

    for (int n = 0; n < 120; n++) begin
      logic [5:0] o, f;
      int r, rst_at;
      r = int'($urandom_range(0, 9));
      f = 6'($urandom);
      case (r)
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: begin o = 6'b000000; f = ($urandom_range(0, 1) == 0) ? 6'b100001 : 6'b100101; end
        3: o = 6'b000100;
        4: o = 6'b001001;
        5: o = 6'b001101;
        6: o = 6'b001111;
        7: o = 6'b000010;
        8: o = 6'($urandom);
        default: o = 6'b000000;
      endcase
      rst_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(o, f, 2, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rst_at);
    end

    #20;
    total++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain pending=%0d want=0", exp_q.size());
      bad++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
